audio_receiver: RTL and testbench
=================================

Name: audio_receiver

Overview:
Slave-mode I2S serial audio receiver, the capture-side counterpart of the team's DAC driver (speaker_control). It samples an external audio_bck / audio_ws / audio_data bus, for example from an ADC or a loopback of the DAC pins. The bus is asynchronous to the system clock. The block deserialises one DATA_W-bit two's-complement word per channel and presents a left/right pair, with a one-cycle valid strobe, to downstream logic such as volume metering or display.

Parameters:
DATA_W, 16, bits captured per channel slot (MSB first); extra bits in longer slots are ignored.
SYNC_STAGES, 2, synchroniser flops on each of audio_bck, audio_ws and audio_data (minimum 2).

Ports:
clk  input  1  system clock; one clock domain. Must be at least 8x the audio_bck frequency.
rst  input  1  reset; asynchronous, active-high.
audio_bck  input  1  serial bit clock from the bus; asynchronous to clk.
audio_ws  input  1  word select: 0 = left, 1 = right. Changes one bck period before the MSB (standard I2S).
audio_data  input  1  serial data; changes on bck falling edge, valid on bck rising edge.
audio_out_left  output  DATA_W  last complete left sample.
audio_out_right  output  DATA_W  last complete right sample.
sample_valid  output  1  one-clk pulse; the left/right pair has just been updated together.
frame_err  output  1  one-clk pulse; a slot ended with fewer than DATA_W bits.
locked  output  1  high once the first audio_ws transition after reset has been seen.

Behaviour:
- Synchronisation
  - Each bus input passes through SYNC_STAGES flops.
  - One additional history flop on the bck path drives edge detection.
  - A bck rising edge event (rise) is defined as synced bck = 1 while history = 0.
  - ws and data are taken from the same synchroniser stage as bck, so all three are mutually aligned.
- Reset (rst = 1, asynchronous)
  - All outputs are 0: audio_out_left, audio_out_right, sample_valid, frame_err, locked.
  - Bit counter = 0; shift register = 0; previous-ws register = 0.
  - Pending-left register and pending-left flag = 0.
  - All synchroniser flops = 0.
  - Reset in mid-frame discards any partial word. locked falls and must be re-acquired.
- State
  - State is UNLOCKED or RUN; locked = (state == RUN).
  - UNLOCKED: on each rise, record ws. On the first rise where ws differs from the recorded value, go to RUN with cur_ch = new ws and count = 0. No bits are captured before this point.
- RUN, each rise, evaluated in this order:
  1. If count < DATA_W: shift data into the LSB of shift_reg and increment count. If count becomes DATA_W, the word is complete for cur_ch.
  2. If ws differs from the previous ws: if count (after step 1) < DATA_W, pulse frame_err and discard the word. Then set cur_ch = ws and count = 0.
  - The bit sampled on the ws-change edge belongs to the previous channel (the I2S one-bit delay). A 16-bck slot therefore completes exactly on the ws-change edge.
  - Bits beyond DATA_W in a slot are ignored (count saturates at DATA_W).
- Completion and output update
  - Left word complete: store it in pending-left and set the pending flag. Outputs are not changed.
  - Right word complete with pending flag set: update audio_out_left (from pending-left) and audio_out_right in the same cycle, pulse sample_valid, clear the pending flag.
  - Right word complete without pending flag: drop the word; no valid pulse and no error.
  - frame_err on either channel clears the pending flag.
- Timing and pulse rules
  - Output update, sample_valid and frame_err are registered on the clk cycle after the rise is detected.
  - Latency from the bck pin edge to sample_valid is SYNC_STAGES + 2 clk cycles.
  - sample_valid and frame_err never exceed one clk per bck edge and are never both high.
  - Outputs hold their values between updates.

Test Plan:
1. Nominal frame. clk = 40 MHz, bck = clk/16, ws toggling every 16 bck. Send a warm-up slot, then left = 16'h4000, right = 16'h3FFF.
   -> One sample_valid pulse 4 clk after the bck rise on the ws-change edge following the right LSB; audio_out_left = 16'h4000, audio_out_right = 16'h3FFF; frame_err stays 0.
2. Lock-up. Stream with ws starting high mid-slot after reset.
   -> locked = 0 and no sample_valid until the first ws transition; the first valid pair is the first complete left+right frame after lock.
3. Short slot. Left slot of only 8 bck, then a full right slot of 16'h1234.
   -> frame_err pulses once at the 8-bit ws change; no sample_valid for that frame; outputs keep their previous values.
4. Long slots. 24 bck per slot, left = 24'h8001AA, right = 24'h7FFF55.
   -> audio_out_left = 16'h8001, audio_out_right = 16'h7FFF; sample_valid once per frame.
5. Reset mid-frame. Assert rst after 5 bits of a left word, release, then send two full frames.
   -> All outputs are 0 during reset; locked re-asserts on the next ws change; the first sample_valid carries the first full frame sent after release.
6. Back-to-back frames. Send 4 frames of incrementing values (L = 16'h0001..0004, R = 16'hFFFF..FFFC).
   -> Exactly 4 sample_valid pulses, one bck frame period apart, each with the matching pair.

Source files
------------

// File: rtl/audio_receiver.sv
// Slave-mode I2S receiver: synchronises an external bck/ws/data bus into clk_sys,
// deserialises one DATA_W-bit word per channel and presents left/right pairs with a valid strobe.
module audio_receiver #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              audio_bck,
  input  logic              audio_ws,
  input  logic              audio_data,
  output logic [DATA_W-1:0] audio_out_left,
  output logic [DATA_W-1:0] audio_out_right,
  output logic              sample_valid,
  output logic              frame_err,
  output logic              locked
);

  // state     | meaning
  // UNLOCKED  | waiting for the first ws transition; no bits captured
  // RUN       | aligned to slot boundaries; capturing words
  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_RUN      = 1'b1;

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  logic [SYNC_STAGES-1:0] bck_sync_q, bck_sync_d;
  logic [SYNC_STAGES-1:0] ws_sync_q, ws_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic bck_hist_q, bck_hist_d;
  logic rise_q, rise_d;
  logic ws_r_q, ws_r_d;
  logic data_r_q, data_r_d;

  logic [0:0]        state_q, state_d;
  logic              seen_q, seen_d;
  logic              prev_ws_q, prev_ws_d;
  logic              cur_ch_q, cur_ch_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] pend_left_q, pend_left_d;
  logic [DATA_W-1:0] out_left_q, out_left_d;
  logic [DATA_W-1:0] out_right_q, out_right_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] shift_nx;
  logic [CNT_W-1:0]  count_nx;
  logic              word_done;

  // All three bus lines share one stage depth so ws/data stay aligned with the bck edge.
  always_comb begin
    bck_sync_d  = {bck_sync_q[SYNC_STAGES-2:0], audio_bck};
    ws_sync_d   = {ws_sync_q[SYNC_STAGES-2:0], audio_ws};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], audio_data};
    bck_hist_d  = bck_sync_q[SYNC_STAGES-1];
    rise_d      = bck_sync_q[SYNC_STAGES-1] & ~bck_hist_q;
    ws_r_d      = ws_sync_q[SYNC_STAGES-1];
    data_r_d    = data_sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    state_d     = state_q;
    seen_d      = seen_q;
    prev_ws_d   = prev_ws_q;
    cur_ch_d    = cur_ch_q;
    count_d     = count_q;
    shift_d     = shift_q;
    pend_d      = pend_q;
    pend_left_d = pend_left_q;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    shift_nx    = shift_q;
    count_nx    = count_q;
    word_done   = 1'b0;

    if (rise_q) begin
      prev_ws_d = ws_r_q;
      seen_d    = 1'b1;
      case (state_q)
        ST_UNLOCKED: begin
          // The first rise only records ws; a transition needs a prior sample.
          if (seen_q && (ws_r_q != prev_ws_q)) begin
            state_d  = ST_RUN;
            cur_ch_d = ws_r_q;
            count_d  = '0;
          end
        end
        default: begin
          if (count_q < CNT_FULL) begin
            shift_nx  = {shift_q[DATA_W-2:0], data_r_q};
            count_nx  = count_q + CNT_W'(1);
            word_done = (count_nx == CNT_FULL);
          end
          shift_d = shift_nx;
          count_d = count_nx;

          if (word_done) begin
            if (!cur_ch_q) begin
              pend_left_d = shift_nx;
              pend_d      = 1'b1;
            end else if (pend_q) begin
              out_left_d  = pend_left_q;
              out_right_d = shift_nx;
              valid_d     = 1'b1;
              pend_d      = 1'b0;
            end
          end

          // The bit on the ws-change edge still belongs to the outgoing slot.
          if (ws_r_q != prev_ws_q) begin
            if (count_nx < CNT_FULL) begin
              err_d  = 1'b1;
              pend_d = 1'b0;
            end
            cur_ch_d = ws_r_q;
            count_d  = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bck_sync_q  <= '0;
      ws_sync_q   <= '0;
      data_sync_q <= '0;
      bck_hist_q  <= 1'b0;
      rise_q      <= 1'b0;
      ws_r_q      <= 1'b0;
      data_r_q    <= 1'b0;
      state_q     <= ST_UNLOCKED;
      seen_q      <= 1'b0;
      prev_ws_q   <= 1'b0;
      cur_ch_q    <= 1'b0;
      count_q     <= '0;
      shift_q     <= '0;
      pend_q      <= 1'b0;
      pend_left_q <= '0;
      out_left_q  <= '0;
      out_right_q <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      bck_sync_q  <= bck_sync_d;
      ws_sync_q   <= ws_sync_d;
      data_sync_q <= data_sync_d;
      bck_hist_q  <= bck_hist_d;
      rise_q      <= rise_d;
      ws_r_q      <= ws_r_d;
      data_r_q    <= data_r_d;
      state_q     <= state_d;
      seen_q      <= seen_d;
      prev_ws_q   <= prev_ws_d;
      cur_ch_q    <= cur_ch_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      pend_q      <= pend_d;
      pend_left_q <= pend_left_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign audio_out_left  = out_left_q;
  assign audio_out_right = out_right_q;
  assign sample_valid    = valid_q;
  assign frame_err       = err_q;
  assign locked          = (state_q == ST_RUN);

endmodule

// File: tb/tb_audio_receiver.sv
// Bench for audio_receiver: directed I2S streams, a per-bck-rise behavioural model
// checked against the DUT every clk, plus literal expectations per scenario.
`timescale 1ns/1ps
module tb_audio_receiver;
  localparam int DW  = 16;
  localparam int LAT = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic audio_bck = 1'b0, audio_ws = 1'b0, audio_data = 1'b0;
  logic [DW-1:0] audio_out_left, audio_out_right;
  logic sample_valid, frame_err, locked;

  audio_receiver #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .audio_bck(audio_bck), .audio_ws(audio_ws),
    .audio_data(audio_data), .audio_out_left(audio_out_left),
    .audio_out_right(audio_out_right), .sample_valid(sample_valid),
    .frame_err(frame_err), .locked(locked)
  );

  always #12.5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic v; logic e; logic [DW-1:0] l; logic [DW-1:0] r; logic lk; } ev_t;
  typedef struct { logic ch; logic d; } bit_t;
  ev_t  evq[$];
  bit_t sq[$];

  // model state (plain integers, one update per bck rise)
  bit m_locked, m_seen, m_prev, m_ch, m_pend;
  int m_cnt, m_word, m_pl, m_l, m_r;

  logic exp_v, exp_e, exp_lk;
  logic [DW-1:0] exp_l, exp_r;
  int n_valid, n_err;
  logic [DW-1:0] got_l[$], got_r[$];
  int got_c[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_seen = 0; m_prev = 0; m_ch = 0; m_pend = 0;
    m_cnt = 0; m_word = 0; m_pl = 0; m_l = 0; m_r = 0;
  endtask

  task automatic model_rise(input logic ws, input logic d);
    ev_t ev;
    ev.v = 0; ev.e = 0;
    if (!m_locked) begin
      if (m_seen && ws != m_prev) begin m_locked = 1; m_ch = ws; m_cnt = 0; end
    end else begin
      if (m_cnt < DW) begin
        m_word = (m_word * 2 + int'(d)) % (1 << DW);
        m_cnt++;
        if (m_cnt == DW) begin
          if (m_ch == 0) begin m_pl = m_word; m_pend = 1; end
          else if (m_pend) begin m_l = m_pl; m_r = m_word; ev.v = 1; m_pend = 0; end
        end
      end
      if (ws != m_prev) begin
        if (m_cnt < DW) begin ev.e = 1; m_pend = 0; end
        m_ch = ws; m_cnt = 0;
      end
    end
    m_seen = 1; m_prev = ws;
    ev.l = DW'(m_l); ev.r = DW'(m_r); ev.lk = m_locked; ev.due = cyc + LAT;
    evq.push_back(ev);
  endtask

  // per-cycle compare against the model
  initial begin
    ev_t ev;
    exp_l = '0; exp_r = '0; exp_lk = 0;
    forever begin
      @(negedge clk); #1;
      exp_v = 0; exp_e = 0;
      while (evq.size() > 0 && evq[0].due == cyc) begin
        ev = evq.pop_front();
        exp_v = ev.v; exp_e = ev.e; exp_l = ev.l; exp_r = ev.r; exp_lk = ev.lk;
      end
      chk("sample_valid", 32'(sample_valid), 32'(exp_v));
      chk("frame_err", 32'(frame_err), 32'(exp_e));
      chk("locked", 32'(locked), 32'(exp_lk));
      chk("out_left", 32'(audio_out_left), 32'(exp_l));
      chk("out_right", 32'(audio_out_right), 32'(exp_r));
      if (sample_valid === 1'b1) begin
        n_valid++;
        got_l.push_back(audio_out_left); got_r.push_back(audio_out_right); got_c.push_back(cyc);
      end
      if (frame_err === 1'b1) n_err++;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic ws, input logic d);
    audio_bck = 0; audio_ws = ws; audio_data = d;
    repeat (8) @(negedge clk);
    audio_bck = 1; model_rise(ws, d);
    repeat (8) @(negedge clk);
  endtask

  task automatic add_slot(input logic ch, input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) sq.push_back('{ch, val[i]});
  endtask

  // ws leads data by one bit: each rise carries the channel of the following bit
  task automatic send_stream();
    for (int i = 0; i < sq.size(); i++)
      send_bit((i + 1 < sq.size()) ? sq[i+1].ch : sq[i].ch, sq[i].d);
    sq.delete();
    repeat (10) @(negedge clk);
  endtask

  task automatic start_test();
    n_valid = 0; n_err = 0;
    got_l.delete(); got_r.delete(); got_c.delete();
  endtask

  task automatic do_reset();
    audio_bck = 0; audio_ws = 0; audio_data = 0;
    rst = 1; evq.delete(); model_reset();
    exp_l = '0; exp_r = '0; exp_lk = 0;
    repeat (4) @(negedge clk);
    #2;
    chk("rst_left", 32'(audio_out_left), 32'h0);
    chk("rst_right", 32'(audio_out_right), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // 1: nominal frame
    start_test();
    add_slot(1, 32'h0, 16); add_slot(0, 32'h4000, 16); add_slot(1, 32'h3FFF, 16); add_slot(0, 32'h0, 1);
    send_stream();
    chk("t1_nvalid", n_valid, 1); chk("t1_nerr", n_err, 0);
    chk("t1_left", 32'(audio_out_left), 32'h4000); chk("t1_right", 32'(audio_out_right), 32'h3FFF);

    // 2: lock-up with ws high mid-slot
    do_reset(); start_test();
    add_slot(1, 32'h55, 6); send_stream();
    chk("t2_prelock", 32'(locked), 32'h0);
    add_slot(1, 32'h1, 1);
    add_slot(0, 32'h1111, 16); add_slot(1, 32'h2222, 16);
    add_slot(0, 32'h3333, 16); add_slot(1, 32'h4444, 16); add_slot(0, 32'h0, 1);
    send_stream();
    chk("t2_nvalid", n_valid, 2); chk("t2_nerr", n_err, 0);
    if (got_l.size() > 0) begin
      chk("t2_first_l", 32'(got_l[0]), 32'h1111); chk("t2_first_r", 32'(got_r[0]), 32'h2222);
    end
    chk("t2_left", 32'(audio_out_left), 32'h3333); chk("t2_right", 32'(audio_out_right), 32'h4444);

    // 3: short left slot
    do_reset(); start_test();
    add_slot(1, 32'h0, 16); add_slot(0, 32'hAAAA, 16); add_slot(1, 32'h5555, 16);
    add_slot(0, 32'hFF, 8); add_slot(1, 32'h1234, 16); add_slot(0, 32'h0, 1);
    send_stream();
    chk("t3_nvalid", n_valid, 1); chk("t3_nerr", n_err, 1);
    chk("t3_left", 32'(audio_out_left), 32'hAAAA); chk("t3_right", 32'(audio_out_right), 32'h5555);

    // 4: 24-bit slots
    do_reset(); start_test();
    add_slot(1, 32'h0, 24); add_slot(0, 32'h8001AA, 24); add_slot(1, 32'h7FFF55, 24);
    add_slot(0, 32'h123456, 24); add_slot(1, 32'h654321, 24); add_slot(0, 32'h0, 1);
    send_stream();
    chk("t4_nvalid", n_valid, 2); chk("t4_nerr", n_err, 0);
    if (got_l.size() > 0) begin
      chk("t4_first_l", 32'(got_l[0]), 32'h8001); chk("t4_first_r", 32'(got_r[0]), 32'h7FFF);
    end
    chk("t4_left", 32'(audio_out_left), 32'h1234); chk("t4_right", 32'(audio_out_right), 32'h6543);

    // 5: reset after 5 bits of a left word
    add_slot(0, 32'h16, 5); send_stream();
    do_reset(); start_test();
    add_slot(1, 32'h0, 16); add_slot(0, 32'hBEEF, 16); add_slot(1, 32'hCAFE, 16);
    add_slot(0, 32'h0F0F, 16); add_slot(1, 32'hF0F0, 16); add_slot(0, 32'h0, 1);
    send_stream();
    chk("t5_nvalid", n_valid, 2); chk("t5_nerr", n_err, 0);
    if (got_l.size() > 0) begin
      chk("t5_first_l", 32'(got_l[0]), 32'hBEEF); chk("t5_first_r", 32'(got_r[0]), 32'hCAFE);
    end

    // 6: back-to-back frames
    do_reset(); start_test();
    add_slot(1, 32'h0, 16);
    for (int i = 0; i < 4; i++) begin
      add_slot(0, 32'(i + 1), 16); add_slot(1, 32'hFFFF - 32'(i), 16);
    end
    add_slot(0, 32'h0, 1);
    send_stream();
    chk("t6_nvalid", n_valid, 4); chk("t6_nerr", n_err, 0);
    for (int i = 0; i < got_l.size() && i < 4; i++) begin
      chk("t6_left", 32'(got_l[i]), 32'(i + 1));
      chk("t6_right", 32'(got_r[i]), 32'hFFFF - 32'(i));
      if (i > 0) chk("t6_spacing", got_c[i] - got_c[i-1], 512);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
